// File: rtl/rob_pkg.sv
// Shared types and helpers for the ROB retire slice.
package rob_pkg;

  localparam int RENTRIES_DEF = 16;
  localparam int RSLOTS_DEF   = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    EXC   = 2'd1,
    FLUSH = 2'd2
  } retire_state_t;

  // Modulo advance of a ROB index; valid while idx < entries and n <= entries,
  // which avoids a general divider when RENTRIES is not a power of two.
  function automatic int rob_inc(input int idx, input int n, input int entries = RENTRIES_DEF);
    int sum;
    sum = idx + n;
    if (sum >= entries) sum = sum - entries;
    return sum;
  endfunction

endpackage

// File: rtl/rob_commit_scan.sv
// Combinational in-order scan from the head: which slots may retire this cycle.
module rob_commit_scan
  import rob_pkg::*;
#(
  parameter int RENTRIES = RENTRIES_DEF,
  parameter int RSLOTS   = RSLOTS_DEF,
  parameter int RBW      = $clog2(RENTRIES)
) (
  input  logic [RBW-1:0]        head,
  input  logic [RENTRIES-1:0]   rob_v,
  input  logic [RENTRIES-1:0]   rob_done,
  input  logic [RENTRIES-1:0]   rob_exc,
  input  logic                  stall,
  output logic [RSLOTS-1:0]     commit_mask,
  output logic [RSLOTS*RBW-1:0] commit_rid,
  output logic [2:0]            commit_cnt,
  output logic [RENTRIES-1:0]   free_mask,
  output logic                  head_exc
);

  logic [RBW-1:0] slot_idx [RSLOTS];
  logic           alive;

  always_comb begin
    for (int k = 0; k < RSLOTS; k++) begin
      slot_idx[k] = RBW'(rob_inc(int'(head), k, RENTRIES));
    end
  end

  // A slot retires only while every older slot retired; the first miss ends the scan.
  always_comb begin
    commit_mask = '0;
    commit_rid  = '0;
    commit_cnt  = '0;
    free_mask   = '0;
    alive       = !stall;
    for (int k = 0; k < RSLOTS; k++) begin
      if (alive && rob_v[slot_idx[k]] && rob_done[slot_idx[k]] && !rob_exc[slot_idx[k]]) begin
        commit_mask[k]             = 1'b1;
        commit_rid[k*RBW +: RBW]   = slot_idx[k];
        free_mask[slot_idx[k]]     = 1'b1;
        commit_cnt                 = commit_cnt + 3'd1;
      end else begin
        alive = 1'b0;
      end
    end
    head_exc = !stall && rob_v[head] && rob_done[head] && rob_exc[head];
  end

endmodule

// File: rtl/rob_retire.sv
// ROB retire stage: in-order commit from the head plus exception/flush handshake.
module rob_retire
  import rob_pkg::*;
#(
  parameter int RENTRIES = RENTRIES_DEF,
  parameter int RSLOTS   = RSLOTS_DEF,
  parameter int RBW      = $clog2(RENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RENTRIES-1:0]   rob_v_i,
  input  logic [RENTRIES-1:0]   rob_done_i,
  input  logic [RENTRIES-1:0]   rob_exc_i,
  input  logic [RBW-1:0]        rob_tail_i,
  input  logic                  commit_stall_i,
  input  logic                  exc_ack_i,
  output logic [RBW-1:0]        rob_head_o,
  output logic [RSLOTS-1:0]     commit_v_o,
  output logic [RSLOTS*RBW-1:0] commit_rid_o,
  output logic [2:0]            commit_cnt_o,
  output logic [RENTRIES-1:0]   rob_free_o,
  output logic                  exc_req_o,
  output logic [RBW-1:0]        exc_rid_o,
  output logic                  busy_o
);

  retire_state_t state, state_nxt;

  logic [RSLOTS-1:0]     scan_mask;
  logic [RSLOTS*RBW-1:0] scan_rid;
  logic [2:0]            scan_cnt;
  logic [RENTRIES-1:0]   scan_free;
  logic                  scan_head_exc;

  logic [RBW-1:0]        head_nxt;
  logic [RSLOTS-1:0]     commit_v_nxt;
  logic [RSLOTS*RBW-1:0] commit_rid_nxt;
  logic [2:0]            commit_cnt_nxt;
  logic [RENTRIES-1:0]   free_nxt;
  logic                  exc_req_nxt;
  logic [RBW-1:0]        exc_rid_nxt;
  logic [RBW-1:0]        tail_safe;

  rob_commit_scan #(
    .RENTRIES (RENTRIES),
    .RSLOTS   (RSLOTS),
    .RBW      (RBW)
  ) u_scan (
    .head        (rob_head_o),
    .rob_v       (rob_v_i),
    .rob_done    (rob_done_i),
    .rob_exc     (rob_exc_i),
    .stall       (commit_stall_i),
    .commit_mask (scan_mask),
    .commit_rid  (scan_rid),
    .commit_cnt  (scan_cnt),
    .free_mask   (scan_free),
    .head_exc    (scan_head_exc)
  );

  // Keep the head inside 0..RENTRIES-1 even if the allocator hands over a bad tail.
  if (RENTRIES == (1 << RBW)) begin : g_tail_pow2
    assign tail_safe = rob_tail_i;
  end else begin : g_tail_clamp
    assign tail_safe = (int'(rob_tail_i) < RENTRIES) ? rob_tail_i : '0;
  end

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    state_nxt      = state;
    head_nxt       = rob_head_o;
    commit_v_nxt   = '0;
    commit_rid_nxt = '0;
    commit_cnt_nxt = '0;
    free_nxt       = '0;
    exc_req_nxt    = exc_req_o;
    exc_rid_nxt    = exc_rid_o;
    unique case (state)
      RUN: begin
        if (scan_head_exc) begin
          state_nxt   = EXC;
          exc_req_nxt = 1'b1;
          exc_rid_nxt = rob_head_o;
        end else begin
          commit_v_nxt   = scan_mask;
          commit_rid_nxt = scan_rid;
          commit_cnt_nxt = scan_cnt;
          free_nxt       = scan_free;
          head_nxt       = RBW'(rob_inc(int'(rob_head_o), int'(scan_cnt), RENTRIES));
        end
      end
      EXC: begin
        if (exc_ack_i) state_nxt = FLUSH;
      end
      FLUSH: begin
        free_nxt    = rob_v_i;
        head_nxt    = tail_safe;
        exc_req_nxt = 1'b0;
        state_nxt   = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      rob_head_o   <= '0;
      commit_v_o   <= '0;
      commit_rid_o <= '0;
      commit_cnt_o <= '0;
      rob_free_o   <= '0;
      exc_req_o    <= 1'b0;
      exc_rid_o    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state        <= state_nxt;
      rob_head_o   <= head_nxt;
      commit_v_o   <= commit_v_nxt;
      commit_rid_o <= commit_rid_nxt;
      commit_cnt_o <= commit_cnt_nxt;
      rob_free_o   <= free_nxt;
      exc_req_o    <= exc_req_nxt;
      exc_rid_o    <= exc_rid_nxt;
    end
  end

  assign busy_o = (state != RUN);

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: directed scenarios plus random traffic against a queue-free model.
module tb_rob_retire;

  localparam int N  = 16;
  localparam int S  = 2;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  rob_v, rob_done, rob_exc;
  logic [BW-1:0] rob_tail;
  logic          commit_stall, exc_ack;

  logic [BW-1:0]   rob_head_o;
  logic [S-1:0]    commit_v_o;
  logic [S*BW-1:0] commit_rid_o;
  logic [2:0]      commit_cnt_o;
  logic [N-1:0]    rob_free_o;
  logic            exc_req_o;
  logic [BW-1:0]   exc_rid_o;
  logic            busy_o;

  rob_retire #(.RENTRIES(N), .RSLOTS(S), .RBW(BW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rob_v_i        (rob_v),
    .rob_done_i     (rob_done),
    .rob_exc_i      (rob_exc),
    .rob_tail_i     (rob_tail),
    .commit_stall_i (commit_stall),
    .exc_ack_i      (exc_ack),
    .rob_head_o     (rob_head_o),
    .commit_v_o     (commit_v_o),
    .commit_rid_o   (commit_rid_o),
    .commit_cnt_o   (commit_cnt_o),
    .rob_free_o     (rob_free_o),
    .exc_req_o      (exc_req_o),
    .exc_rid_o      (exc_rid_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  typedef enum {M_RUN, M_EXC, M_FLUSH} mstate_t;

  mstate_t      m_state;
  int           m_head;
  bit           m_exc_req;
  int           m_exc_rid;
  bit [S-1:0]   e_cv;
  int           e_rid [S];
  int           e_cnt;
  bit [N-1:0]   e_free;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = M_RUN;
    m_head    = 0;
    m_exc_req = 1'b0;
    m_exc_rid = 0;
    e_cv      = '0;
    e_cnt     = 0;
    e_free    = '0;
    for (int k = 0; k < S; k++) e_rid[k] = 0;
  endtask

  // Expected result of the coming edge, from the current inputs and model state.
  task automatic model_eval();
    e_cv   = '0;
    e_cnt  = 0;
    e_free = '0;
    for (int k = 0; k < S; k++) e_rid[k] = 0;
    case (m_state)
      M_RUN: begin
        if (!commit_stall) begin
          if (rob_v[m_head] && rob_done[m_head] && rob_exc[m_head]) begin
            m_state   = M_EXC;
            m_exc_req = 1'b1;
            m_exc_rid = m_head;
          end else begin
            for (int k = 0; k < S; k++) begin
              int idx;
              idx = (m_head + k) % N;
              if (!(rob_v[idx] && rob_done[idx] && !rob_exc[idx])) break;
              e_cv[k]     = 1'b1;
              e_rid[k]    = idx;
              e_free[idx] = 1'b1;
              e_cnt++;
            end
            m_head = (m_head + e_cnt) % N;
          end
        end
      end
      M_EXC: begin
        if (exc_ack) m_state = M_FLUSH;
      end
      M_FLUSH: begin
        e_free    = rob_v;
        m_head    = int'(rob_tail);
        m_exc_req = 1'b0;
        m_state   = M_RUN;
      end
      default: m_state = M_RUN;
    endcase
  endtask

  task automatic compare_all();
    check("head", 32'(rob_head_o), m_head);
    check("commit_v", 32'(commit_v_o), 32'(e_cv));
    check("commit_cnt", 32'(commit_cnt_o), e_cnt);
    check("rob_free", 32'(rob_free_o), 32'(e_free));
    check("exc_req", 32'(exc_req_o), 32'(m_exc_req));
    check("busy", 32'(busy_o), 32'(m_state != M_RUN));
    for (int k = 0; k < S; k++)
      if (e_cv[k]) check("commit_rid", 32'(commit_rid_o[k*BW +: BW]), e_rid[k]);
    if (m_exc_req) check("exc_rid", 32'(exc_rid_o), m_exc_rid);
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    rob_v = '0; rob_done = '0; rob_exc = '0;
    commit_stall = 1'b0; exc_ack = 1'b0;
  endtask

  // Move the head through an exception + flush with the tail at the target.
  task automatic set_head(input int t);
    clear_inputs();
    rob_v[m_head] = 1'b1; rob_done[m_head] = 1'b1; rob_exc[m_head] = 1'b1;
    step();
    clear_inputs();
    exc_ack = 1'b1;
    step();
    exc_ack  = 1'b0;
    rob_tail = BW'(t);
    step();
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    rob_tail = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_head", 32'(rob_head_o), 0);
    check("reset_commit_v", 32'(commit_v_o), 0);
    check("reset_cnt", 32'(commit_cnt_o), 0);
    check("reset_free", 32'(rob_free_o), 0);
    check("reset_exc_req", 32'(exc_req_o), 0);
    check("reset_rids", 32'(commit_rid_o), 0);
    check("reset_exc_rid", 32'(exc_rid_o), 0);
    check("reset_busy", 32'(busy_o), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic two-wide commit.
    rob_v = 16'h000F; rob_done = 16'h000F;
    step();
    check("basic1_cnt", 32'(commit_cnt_o), 2);
    check("basic1_rids", 32'(commit_rid_o), 32'h10);
    check("basic1_free", 32'(rob_free_o), 32'h0003);
    check("basic1_head", 32'(rob_head_o), 2);
    rob_v = 16'h000C; rob_done = 16'h000C;
    step();
    check("basic2_rids", 32'(commit_rid_o), 32'h32);
    check("basic2_head", 32'(rob_head_o), 4);

    // Partial completion.
    set_head(5);
    rob_v = 16'h0060; rob_done = 16'h0020;
    step();
    check("partial1_cnt", 32'(commit_cnt_o), 1);
    check("partial1_v", 32'(commit_v_o), 32'b01);
    check("partial1_head", 32'(rob_head_o), 6);
    rob_v = 16'h0040; rob_done = 16'h0040;
    step();
    check("partial2_cnt", 32'(commit_cnt_o), 1);
    check("partial2_head", 32'(rob_head_o), 7);

    // Wrap from 15 to 0.
    set_head(15);
    rob_v = 16'h8001; rob_done = 16'h8001;
    step();
    check("wrap_rids", 32'(commit_rid_o), 32'h0F);
    check("wrap_free", 32'(rob_free_o), 32'h8001);
    check("wrap_head", 32'(rob_head_o), 1);

    // Exception at head, held, then acknowledged and flushed.
    set_head(3);
    rob_v = 16'h0018; rob_done = 16'h0018; rob_exc = 16'h0008;
    step();
    check("exc_cnt", 32'(commit_cnt_o), 0);
    for (int c = 0; c < 5; c++) begin
      commit_stall = 1'($urandom_range(0, 1));
      step();
      check("exc_hold_req", 32'(exc_req_o), 1);
      check("exc_hold_rid", 32'(exc_rid_o), 3);
    end
    commit_stall = 1'b0;
    exc_ack = 1'b1;
    step();
    check("ack_busy", 32'(busy_o), 1);
    exc_ack = 1'b0; rob_tail = 4'd9; rob_v = 16'h0F18;
    step();
    check("flush_free", 32'(rob_free_o), 32'h0F18);
    check("flush_head", 32'(rob_head_o), 9);
    check("flush_exc_req", 32'(exc_req_o), 0);
    check("flush_busy", 32'(busy_o), 0);

    // Stall, then an exception one slot behind the head.
    clear_inputs();
    rob_v = 16'h0600; rob_done = 16'h0600; commit_stall = 1'b1;
    step();
    check("stall_cnt", 32'(commit_cnt_o), 0);
    check("stall_head", 32'(rob_head_o), 9);
    commit_stall = 1'b0; rob_exc = 16'h0400;
    step();
    check("behind_cnt", 32'(commit_cnt_o), 1);
    check("behind_rid", 32'(commit_rid_o[BW-1:0]), 9);
    check("behind_head", 32'(rob_head_o), 10);
    rob_v = 16'h0400; rob_done = 16'h0400;
    step();
    check("behind_exc_req", 32'(exc_req_o), 1);
    check("behind_exc_rid", 32'(exc_rid_o), 10);

    // Asynchronous reset while in EXC.
    #3;
    rst = 1'b1;
    #1;
    check("areset_exc_req", 32'(exc_req_o), 0);
    check("areset_head", 32'(rob_head_o), 0);
    check("areset_busy", 32'(busy_o), 0);
    check("areset_commit_v", 32'(commit_v_o), 0);
    check("areset_cnt", 32'(commit_cnt_o), 0);
    check("areset_free", 32'(rob_free_o), 0);
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rob_v        = N'($urandom | $urandom);
      rob_done     = N'($urandom | $urandom);
      rob_exc      = N'($urandom & $urandom & $urandom);
      rob_tail     = BW'($urandom_range(0, N - 1));
      commit_stall = ($urandom_range(0, 7) == 0);
      exc_ack      = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- Retire end of the re-order buffer; the queue-side allocator fills ROB entries at the tail, and this block drains them in order from the head.
- Commits up to RSLOTS completed entries per clock and frees their valid bits.
- Advances the head pointer and runs the exception handshake with the front end, including the post-exception ROB flush.
- Sits between the ROB valid/done/exception arrays and the register-rename free logic.

Parameters:
RENTRIES, 16, number of ROB entries (≥4, power of two not required)
RSLOTS, 2, max entries retired per clock (1..4)
RBW, $clog2(RENTRIES), ROB index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rob_v_i  in  RENTRIES  entry valid (allocated)
rob_done_i  in  RENTRIES  entry finished execution
rob_exc_i  in  RENTRIES  entry finished with exception
rob_tail_i  in  RBW  current allocation tail (flush target)
commit_stall_i  in  1  block all commits this cycle
exc_ack_i  in  1  front end accepted exception, redirect done
rob_head_o  out  RBW  registered head pointer
commit_v_o  out  RSLOTS  slot k committed last edge
commit_rid_o  out  RSLOTS*RBW  ROB id per commit slot
commit_cnt_o  out  3  number of commits last edge (0..RSLOTS)
rob_free_o  out  RENTRIES  one-cycle mask of entries to clear
exc_req_o  out  1  exception pending at head
exc_rid_o  out  RBW  ROB id of excepting entry
busy_o  out  1  state != RUN

Behaviour:
- Reset (asynchronous, rst=1) forces:
  - state=RUN, head=0;
  - commit_v_o, commit_cnt_o, rob_free_o, exc_req_o all 0;
  - commit_rid_o and exc_rid_o 0.
- Deasserting rst takes effect at the next clk edge.
- All outputs are registered: a decision made from inputs in cycle N is visible after edge N+1.
- State RUN, commit scan for k = 0..RSLOTS-1, idx = (head+k) mod RENTRIES:
  - Slot k commits iff !commit_stall_i, slot k-1 committed (k=0 exempt), rob_v_i[idx], rob_done_i[idx] and !rob_exc_i[idx].
  - The scan stops at the first slot that fails.
  - Wrap uses modulo RENTRIES; head never equals an index outside 0..RENTRIES-1.
- On the edge after a RUN scan:
  - commit_v_o[k], commit_rid_o[k] = idx and rob_free_o[idx] are set for each committed slot.
  - commit_cnt_o = number committed.
  - head <= (head+cnt) mod RENTRIES.
- Exception at head:
  - Condition: in RUN, !commit_stall_i, rob_v_i[head] & rob_done_i[head] & rob_exc_i[head].
  - Zero commits; state <= EXC; exc_req_o <= 1; exc_rid_o <= head.
  - An excepting entry at k>0 only terminates the scan; it is handled once it reaches the head.
- State EXC:
  - exc_req_o held high, exc_rid_o stable, no commits.
  - commit_stall_i is ignored.
  - On exc_ack_i=1: state <= FLUSH.
- State FLUSH (exactly one cycle):
  - rob_free_o <= rob_v_i (every allocated entry freed); head <= rob_tail_i.
  - exc_req_o <= 0; commit_cnt_o <= 0.
  - state <= RUN.
- exc_ack_i outside EXC is ignored.
- Empty ROB (rob_v_i[head]=0): no commit, head unchanged.
- Full ROB (all valid, head==tail): a normal scan applies, no special case.
- rob_free_o, commit_v_o and commit_cnt_o are single-cycle pulses; they are 0 in any cycle with no commit/flush.
- busy_o = (state != RUN), combinational from the state register.
- Reset mid-EXC or mid-FLUSH returns to RUN with head=0 and no pending exception.

Decomposition:
- Shared package rob_pkg:
  - retire_state_t enum {RUN, EXC, FLUSH};
  - RENTRIES/RSLOTS/RBW defaults;
  - function rob_inc(idx, n) for modulo wrap.
- One sub-module, rob_commit_scan: purely combinational in-order scan producing the per-slot commit mask, count and head-exception flag.
- Top rob_retire holds the state machine and the output registers.

Test Plan:
- Basic commit: RENTRIES=16, RSLOTS=2, head=0, entries 0-3 valid+done -> cycle1 commit_cnt=2, rids 0,1, rob_free_o=0x0003, head=2; cycle2 rids 2,3, head=4.
- Partial completion: entries 5,6 valid, only 5 done, head=5 -> commit_cnt=1, commit_v=01, head=6; then 6 done -> commit_cnt=1, head=7.
- Wrap: head=15, entries 15 and 0 valid+done -> rids 15,0, rob_free_o=0x8001, head=1.
- Exception: head=3, entry 3 exc, entry 4 done -> no commit, exc_req_o=1, exc_rid_o=3 held for 5 cycles; then exc_ack_i pulse -> next edge rob_free_o=rob_v_i, head=rob_tail_i=9, exc_req_o=0, busy_o=0.
- Stall/exception behind head: commit_stall_i=1 with ready entries -> commit_cnt=0, head unchanged; entry 1 exc behind done entry 0 -> commits 0 only, EXC entered the following cycle.
- Async reset while in EXC: rst pulse mid-cycle -> immediately exc_req_o=0, head=0, busy_o=0, all pulses 0.
